// File: rtl/sha_digest_uart_serializer_if.sv
// Handshake bundle between the SHA digest source, the serializer and the
// UART transmitter. The serializer uses the master view, while the
// digest source and transmitter side use the slave view.
interface sha_digest_uart_serializer_if #(
  parameter int DIGEST_BITS = 256
);
  logic [DIGEST_BITS-1:0] digest_in;
  logic                   digest_valid;
  logic                   ready;
  logic                   tx_start;
  logic [7:0]             tx_data;
  logic                   tx_done;
  logic                   done;

  modport master (
    input  digest_in, digest_valid, tx_done,
    output ready, tx_start, tx_data, done
  );

  modport slave (
    output digest_in, digest_valid, tx_done,
    input  ready, tx_start, tx_data, done
  );
endinterface

// File: rtl/sha_digest_uart_serializer.sv
// Digest-to-UART feeder.
// Accepts one digest and splits it MSB-first into characters, which are
// either raw bytes or lowercase hex ASCII. A CR LF pair can optionally be
// appended. Each character is held on tx_data with tx_start high until the
// transmitter reports tx_done.
module sha_digest_uart_serializer #(
  parameter int DIGEST_BITS = 256,
  parameter bit HEX_MODE    = 1'b1,
  parameter bit APPEND_CRLF = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  sha_digest_uart_serializer_if.master bus
);

  localparam int DIGEST_CHARS = HEX_MODE ? DIGEST_BITS / 4 : DIGEST_BITS / 8;
  localparam int NCHARS       = DIGEST_CHARS + (APPEND_CRLF ? 2 : 0);
  localparam int CW           = $clog2(NCHARS + 1);
  localparam int SHIFT        = HEX_MODE ? 4 : 8;

  localparam logic [CW-1:0] LAST_IDX = CW'(NCHARS - 1);
  localparam logic [CW-1:0] DIG_END  = CW'(DIGEST_CHARS);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [DIGEST_BITS-1:0] shreg;
  logic [CW-1:0]          count;
  logic                   done_q;
  logic                   last_char;
  logic [3:0]             nib;
  logic [7:0]             char_c;

  assign last_char = (count == LAST_IDX);
  assign nib       = shreg[DIGEST_BITS-1 -: 4];

  // State register.
  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples the values from before the edge, regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: accept a digest when idle, and return to idle on the final tx_done.
  // NOTE: the default assignment at the top keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.digest_valid)             state_nxt = SEND;
      SEND:    if (bus.tx_done && last_char)     state_nxt = IDLE;
      default:                                   state_nxt = IDLE;
    endcase
  end

  // Datapath: load the digest, then advance one character per tx_done.
  // The done flag is a registered one-cycle pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg  <= '0;
      count  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (bus.digest_valid) begin
          shreg <= bus.digest_in;
          count <= '0;
        end
      end else if (bus.tx_done) begin
        shreg  <= shreg << SHIFT;
        count  <= count + CW'(1);
        done_q <= last_char;
      end
    end
  end

  // Current character, derived only from registers so it stays stable for the whole frame.
  // In hex mode, nibble values a..f map to 8'h61 + (n - 10), which equals 8'h57 + n.
  always_comb begin
    char_c = 8'h00;
    if (count < DIG_END) begin
      if (HEX_MODE) char_c = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
      else          char_c = shreg[DIGEST_BITS-1 -: 8];
    end else if (count == DIG_END) begin
      char_c = 8'h0D;
    end else begin
      char_c = 8'h0A;
    end
  end

  // Output decode from state: idle advertises ready, and send presents the character.
  always_comb begin
    bus.ready    = 1'b1;
    bus.tx_start = 1'b0;
    bus.tx_data  = 8'h00;
    if (state == SEND) begin
      bus.ready    = 1'b0;
      bus.tx_start = 1'b1;
      bus.tx_data  = char_c;
    end
  end

  assign bus.done = done_q;

endmodule

// File: tb/tb_sha_digest_uart_serializer.sv
// Bench for sha_digest_uart_serializer.
// Instance 0 runs in hex mode with CR LF appended; instance 1 runs in raw mode
// without CR LF. Each instance has a transmitter stand-in that pulses tx_done
// K cycles after it latches a character. A message-level model, consisting of
// a queue of expected characters, is checked against the outputs on every cycle.
module tb_sha_digest_uart_serializer;

  localparam int DB = 256;
  localparam int K  = 3;
  localparam logic [DB-1:0] ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [DB-1:0] NIB = {8'h9A, 8'hF0, 240'h0};

  typedef byte unsigned q_t[$];

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  logic [1:0][DB-1:0] din;
  logic [1:0]         dv;
  logic [1:0]         kick;
  logic [1:0]         rdy;
  logic [1:0]         tst;
  logic [1:0]         dn;
  logic [1:0][7:0]    tdat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected character stream for one digest, built directly from the output format.
  function automatic q_t build(input logic [DB-1:0] d, input bit hx, input bit crlf);
    string hd = "0123456789abcdef";
    q_t q;
    for (int i = 0; i < DB / 8; i++) begin
      byte unsigned b = d[DB-1-8*i -: 8];
      if (hx) begin
        q.push_back(hd[b >> 4]);
        q.push_back(hd[b & 8'h0F]);
      end else begin
        q.push_back(b);
      end
    end
    if (crlf) begin
      q.push_back(8'h0D);
      q.push_back(8'h0A);
    end
    return q;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam bit HX = (g == 0);

    sha_digest_uart_serializer_if #(.DIGEST_BITS(DB)) bus ();

    logic         tdone = 1'b0;
    byte unsigned rec[$];
    byte unsigned exp_q[$];
    bit           busy_m = 1'b0;
    bit           done_m = 1'b0;
    int           ndone_pulses = 0;

    assign bus.digest_in    = din[g];
    assign bus.digest_valid = dv[g];
    assign bus.tx_done      = tdone;
    assign rdy[g]           = bus.ready;
    assign tst[g]           = bus.tx_start;
    assign tdat[g]          = bus.tx_data;
    assign dn[g]            = bus.done;

    sha_digest_uart_serializer #(
      .DIGEST_BITS(DB),
      .HEX_MODE   (HX),
      .APPEND_CRLF(HX)
    ) u_dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
    );

    // Message model: a busy message is a queue of pending characters. Each
    // tx_done pops one character, and emptying the queue produces done.
    initial forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        busy_m = 1'b0;
        done_m = 1'b0;
        exp_q.delete();
      end else begin
        done_m = 1'b0;
        if (!busy_m) begin
          if (dv[g]) begin
            exp_q  = build(din[g], HX, HX);
            busy_m = 1'b1;
          end
        end else if (tdone) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin
            busy_m = 1'b0;
            done_m = 1'b1;
          end
        end
      end
    end

    // Transmitter stand-in: latch the character in an idle cycle where
    // tx_start is high, then pulse tx_done K cycles later. Setting kick
    // forces tx_done while no character is pending.
    initial begin
      @(negedge clk);
      forever begin
        if (reset_n && tst[g]) begin
          rec.push_back(tdat[g]);
          repeat (K - 1) @(negedge clk);
          tdone = 1'b1;
          @(negedge clk);
          tdone = 1'b0;
        end else if (kick[g]) begin
          tdone = 1'b1;
          @(negedge clk);
          tdone = 1'b0;
        end else begin
          @(negedge clk);
        end
      end
    end

    // Per-cycle comparison against the model.
    initial forever begin
      @(negedge clk);
      if (reset_n) begin
        check($sformatf("ready[%0d]", g),    32'(rdy[g]), 32'(!busy_m));
        check($sformatf("tx_start[%0d]", g), 32'(tst[g]), 32'(busy_m));
        check($sformatf("tx_data[%0d]", g),  32'(tdat[g]),
              (busy_m && exp_q.size() > 0) ? 32'(exp_q[0]) : 32'h0);
        check($sformatf("done[%0d]", g),     32'(dn[g]), 32'(done_m));
        if (dn[g]) ndone_pulses++;
      end
    end
  end

  task automatic send(input int g, input logic [DB-1:0] d);
    din[g] = d;
    dv[g]  = 1'b1;
    @(negedge clk);
    dv[g]  = 1'b0;
  endtask

  task automatic wait_done(input int g, input int budget);
    int n = 0;
    while (!dn[g] && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("done_seen[%0d]", g), 32'(dn[g]), 32'h1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int base;
    int nd0;
    int n;
    logic [DB-1:0] seq;

    din  = '0;
    dv   = '0;
    kick = '0;
    repeat (2) @(negedge clk);

    // Reset values.
    check("rst_ready",    32'(rdy),     32'h3);
    check("rst_tx_start", 32'(tst),     32'h0);
    check("rst_tx_data0", 32'(tdat[0]), 32'h0);
    check("rst_tx_data1", 32'(tdat[1]), 32'h0);
    check("rst_done",     32'(dn),      32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Test 1: hex mode with CR LF, using the SHA256("abc") digest.
    base = g_inst[0].rec.size();
    nd0  = g_inst[0].ndone_pulses;
    send(0, ABC);
    wait_done(0, 400);
    @(negedge clk);
    check("t1_frames", 32'(g_inst[0].rec.size() - base), 32'd66);
    check("t1_done_pulses", 32'(g_inst[0].ndone_pulses - nd0), 32'd1);
    check("t1_c0",  32'(g_inst[0].rec[base+0]),  32'h62);
    check("t1_c1",  32'(g_inst[0].rec[base+1]),  32'h61);
    check("t1_c2",  32'(g_inst[0].rec[base+2]),  32'h37);
    check("t1_c3",  32'(g_inst[0].rec[base+3]),  32'h38);
    check("t1_c63", 32'(g_inst[0].rec[base+63]), 32'h64);
    check("t1_cr",  32'(g_inst[0].rec[base+64]), 32'h0D);
    check("t1_lf",  32'(g_inst[0].rec[base+65]), 32'h0A);

    // Test 2: raw mode, digest bytes 0x00..0x1F in MSB-first order.
    for (int i = 0; i < 32; i++) seq[DB-1-8*i -: 8] = 8'(i);
    base = g_inst[1].rec.size();
    nd0  = g_inst[1].ndone_pulses;
    send(1, seq);
    wait_done(1, 300);
    @(negedge clk);
    check("t2_frames", 32'(g_inst[1].rec.size() - base), 32'd32);
    check("t2_done_pulses", 32'(g_inst[1].ndone_pulses - nd0), 32'd1);
    for (int i = 0; i < 32; i++)
      check($sformatf("t2_byte%0d", i), 32'(g_inst[1].rec[base+i]), 32'(i));

    // Test 4: a second digest offered during character 5 is ignored.
    base = g_inst[0].rec.size();
    send(0, ABC);
    n = 0;
    while (g_inst[0].rec.size() < base + 6 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t4_reached_char5", 32'(g_inst[0].rec.size() - base), 32'd6);
    din[0] = NIB;
    dv[0]  = 1'b1;
    check("t4_ready_busy", 32'(rdy[0]), 32'h0);
    @(negedge clk);
    dv[0] = 1'b0;
    check("t4_ready_after", 32'(rdy[0]), 32'h0);
    wait_done(0, 400);
    @(negedge clk);
    check("t4_frames", 32'(g_inst[0].rec.size() - base), 32'd66);
    check("t4_c5",  32'(g_inst[0].rec[base+5]),  32'h36);
    check("t4_c12", 32'(g_inst[0].rec[base+12]), 32'h63);

    // Test 5: digest_valid held high through the done cycle.
    base   = g_inst[0].rec.size();
    din[0] = ABC;
    dv[0]  = 1'b1;
    @(negedge clk);
    din[0] = NIB;
    wait_done(0, 400);
    check("t5_ready_in_done", 32'(rdy[0]), 32'h1);
    check("t5_start_in_done", 32'(tst[0]), 32'h0);
    @(negedge clk);
    dv[0] = 1'b0;
    check("t5_start_next", 32'(tst[0]),  32'h1);
    check("t5_char_next",  32'(tdat[0]), 32'h39);
    wait_done(0, 400);
    @(negedge clk);
    check("t5_frames", 32'(g_inst[0].rec.size() - base), 32'd132);
    check("t5_second_c0", 32'(g_inst[0].rec[base+66]), 32'h39);

    // Test 6: reset pulse after the 10th tx_done, then tx_done while idle, then a fresh digest.
    base = g_inst[0].rec.size();
    nd0  = g_inst[0].ndone_pulses;
    send(0, ABC);
    n = 0;
    while (g_inst[0].rec.size() < base + 11 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t6_reached_char10", 32'(g_inst[0].rec.size() - base), 32'd11);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_tx_start", 32'(tst[0]), 32'h0);
    check("t6_rst_ready",    32'(rdy[0]), 32'h1);
    @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    kick[0] = 1'b1;
    repeat (3) @(negedge clk);
    kick[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_idle_ready",    32'(rdy[0]), 32'h1);
    check("t6_idle_tx_start", 32'(tst[0]), 32'h0);
    check("t6_no_done", 32'(g_inst[0].ndone_pulses - nd0), 32'd0);

    // Test 3 follows the reset: nibble map check, restarting from character 0.
    base = g_inst[0].rec.size();
    send(0, NIB);
    wait_done(0, 400);
    @(negedge clk);
    check("t3_frames", 32'(g_inst[0].rec.size() - base), 32'd66);
    check("t3_9",  32'(g_inst[0].rec[base+0]), 32'h39);
    check("t3_A",  32'(g_inst[0].rec[base+1]), 32'h61);
    check("t3_F",  32'(g_inst[0].rec[base+2]), 32'h66);
    check("t3_0",  32'(g_inst[0].rec[base+3]), 32'h30);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
